// File: rtl/trap_decoder_if.sv
// Redirect handshake between the trap decoder (master) and the fetch stage (slave).
interface trap_decoder_if #(
  parameter int XLEN = 32
);
  logic            redirect_valid_o;
  logic [XLEN-1:0] redirect_pc_o;
  logic            redirect_ready_i;

  modport master (
    output redirect_valid_o,
    output redirect_pc_o,
    input  redirect_ready_i
  );

  modport slave (
    input  redirect_valid_o,
    input  redirect_pc_o,
    output redirect_ready_i
  );
endinterface

// File: rtl/trap_decoder.sv
// Trap entry/return sequencer: owns mstatus stacking and redirects fetch into the handler.
// Optional macro TRAP_DOUBLE_FAULT_EN: a nested exception in the handler parks the block in FAULT.
module trap_decoder #(
  parameter int XLEN      = 32,
  parameter int NUM_CAUSE = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 except_flag,
  input  logic [XLEN-1:0]      mcause_in,
  input  logic [XLEN-1:0]      mepc_in,
  input  logic [XLEN-1:0]      mtvec_in,
  input  logic                 mret_in,
  input  logic                 csr_mstatus_we_i,
  input  logic [XLEN-1:0]      csr_mstatus_wdata_i,
  output logic                 except_ack_o,
  trap_decoder_if.master       redirect,
  output logic [XLEN-1:0]      mstatus_out,
  output logic [NUM_CAUSE-1:0] cause_onehot_o,
  output logic                 is_interrupt_o,
  output logic                 in_trap_o
`ifdef TRAP_DOUBLE_FAULT_EN
  ,
  output logic                 double_fault_o
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    HANDLER,
    RETURN
`ifdef TRAP_DOUBLE_FAULT_EN
    ,
    FAULT
`endif
  } state_t;

  state_t state, state_next;

  logic            mie, mpie;
  logic [1:0]      mpp;
  logic [XLEN-1:2] mepc_q;
  logic [XLEN-1:0] pc_q;
  logic            ack_q;

  logic                 trap_ok;
  logic                 accept;
  logic                 mret_take;
  logic                 fault_take;
  logic                 csr_ok;
  logic                 entry_done;
  logic                 return_done;
  logic [XLEN-1:0]      target_pc;
  logic [NUM_CAUSE-1:0] onehot_next;

  wire unused_bits = ^{mepc_in[1:0], csr_mstatus_wdata_i[XLEN-1:13],
                       csr_mstatus_wdata_i[10:8], csr_mstatus_wdata_i[6:4],
                       csr_mstatus_wdata_i[2:0]};

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    mret_take   = 1'b0;
    fault_take  = 1'b0;
    csr_ok      = 1'b1;
    entry_done  = 1'b0;
    return_done = 1'b0;
    trap_ok     = except_flag && (!mcause_in[XLEN-1] || mie);
    case (state)
      IDLE: begin
        if (trap_ok) begin
          accept     = 1'b1;
          state_next = ENTRY;
        end
      end
      ENTRY: begin
        if (redirect.redirect_ready_i) begin
          entry_done = 1'b1;
          state_next = HANDLER;
        end
      end
      HANDLER: begin
        // A pending trap always beats a coincident MRET.
        if (trap_ok) begin
`ifdef TRAP_DOUBLE_FAULT_EN
          if (!mcause_in[XLEN-1]) begin
            fault_take = 1'b1;
            state_next = FAULT;
          end else begin
            accept     = 1'b1;
            state_next = ENTRY;
          end
`else
          accept     = 1'b1;
          state_next = ENTRY;
`endif
        end else if (mret_in) begin
          mret_take  = 1'b1;
          state_next = RETURN;
        end
      end
      RETURN: begin
        if (redirect.redirect_ready_i) begin
          return_done = 1'b1;
          state_next  = IDLE;
        end
      end
`ifdef TRAP_DOUBLE_FAULT_EN
      FAULT: begin
        csr_ok = 1'b0;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Vectored mode only offsets interrupts; reserved modes fall back to direct.
  always_comb begin
    target_pc = {mtvec_in[XLEN-1:2], 2'b00};
    if (mtvec_in[1:0] == 2'b01 && mcause_in[XLEN-1])
      target_pc = {mtvec_in[XLEN-1:2], 2'b00} + {mcause_in[XLEN-3:0], 2'b00};
    onehot_next = '0;
    for (int k = 0; k < NUM_CAUSE; k++)
      onehot_next[k] = (mcause_in[XLEN-2:0] == (XLEN-1)'(k));
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ack_q          <= 1'b0;
      pc_q           <= '0;
      mepc_q         <= '0;
      mie            <= 1'b0;
      mpie           <= 1'b0;
      mpp            <= 2'b11;
      cause_onehot_o <= '0;
      is_interrupt_o <= 1'b0;
      in_trap_o      <= 1'b0;
    end else begin
      ack_q <= accept | fault_take;
      if (accept) begin
        mepc_q         <= mepc_in[XLEN-1:2];
        pc_q           <= target_pc;
        cause_onehot_o <= onehot_next;
        is_interrupt_o <= mcause_in[XLEN-1];
        mpie           <= mie;
        mie            <= 1'b0;
        mpp            <= 2'b11;
      end else if (mret_take) begin
        pc_q <= {mepc_q, 2'b00};
        mie  <= mpie;
        mpie <= 1'b1;
        mpp  <= 2'b11;
      end else if (csr_mstatus_we_i && csr_ok && !fault_take) begin
        mie  <= csr_mstatus_wdata_i[3];
        mpie <= csr_mstatus_wdata_i[7];
        mpp  <= csr_mstatus_wdata_i[12:11];
      end
      if (entry_done) in_trap_o <= 1'b1;
      if (return_done) begin
        in_trap_o      <= 1'b0;
        cause_onehot_o <= '0;
        is_interrupt_o <= 1'b0;
      end
    end
  end

`ifdef TRAP_DOUBLE_FAULT_EN
  always_ff @(posedge clk_in) begin
    if (rst_in)          double_fault_o <= 1'b0;
    else if (fault_take) double_fault_o <= 1'b1;
  end
`endif

  always_comb begin
    mstatus_out        = '0;
    mstatus_out[3]     = mie;
    mstatus_out[7]     = mpie;
    mstatus_out[12:11] = mpp;
  end

  assign except_ack_o              = ack_q;
  assign redirect.redirect_valid_o = (state == ENTRY) || (state == RETURN);
  assign redirect.redirect_pc_o    = pc_q;

endmodule

// File: tb/tb_trap_decoder.sv
// Self-checking bench for trap_decoder: directed scenarios then randomized traffic,
// all compared against a flag-based reference model of trap entry/return.
module tb_trap_decoder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        except_flag;
  logic [31:0] mcause_in, mepc_in, mtvec_in;
  logic        mret_in;
  logic        csr_mstatus_we_i;
  logic [31:0] csr_mstatus_wdata_i;
  logic        except_ack_o;
  logic [31:0] mstatus_out;
  logic [15:0] cause_onehot_o;
  logic        is_interrupt_o;
  logic        in_trap_o;
`ifdef TRAP_DOUBLE_FAULT_EN
  logic        double_fault_o;
`endif

  trap_decoder_if #(.XLEN(32)) redirect_bus ();

  trap_decoder #(.XLEN(32), .NUM_CAUSE(16)) dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .except_flag         (except_flag),
    .mcause_in           (mcause_in),
    .mepc_in             (mepc_in),
    .mtvec_in            (mtvec_in),
    .mret_in             (mret_in),
    .csr_mstatus_we_i    (csr_mstatus_we_i),
    .csr_mstatus_wdata_i (csr_mstatus_wdata_i),
    .except_ack_o        (except_ack_o),
    .redirect            (redirect_bus),
    .mstatus_out         (mstatus_out),
    .cause_onehot_o      (cause_onehot_o),
    .is_interrupt_o      (is_interrupt_o),
    .in_trap_o           (in_trap_o)
`ifdef TRAP_DOUBLE_FAULT_EN
    ,
    .double_fault_o      (double_fault_o)
`endif
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // Reference model: a redirect is either pending (entry or return) or not,
  // and the handler is either running or not.
  bit          m_mie, m_mpie;
  bit [1:0]    m_mpp;
  bit [31:0]   m_mepc, m_pc;
  bit          m_valid, m_ret, m_handler, m_ack, m_int, m_intrap, m_fault;
  bit [15:0]   m_onehot;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic bit [31:0] model_mstatus();
    return (32'(m_mpp) << 11) | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
  endfunction

  task automatic model_step();
    bit        trap_ok, is_irq;
    bit [31:0] code;
    if (rst_in) begin
      m_mie = 0; m_mpie = 0; m_mpp = 2'b11; m_mepc = 0; m_pc = 0;
      m_valid = 0; m_ret = 0; m_handler = 0; m_ack = 0;
      m_int = 0; m_intrap = 0; m_onehot = 0; m_fault = 0;
      return;
    end
    m_ack = 0;
    if (m_fault) return;
    is_irq  = mcause_in[31];
    code    = mcause_in & 32'h7FFF_FFFF;
    trap_ok = except_flag && (!is_irq || m_mie);
    if (!m_valid && trap_ok) begin
`ifdef TRAP_DOUBLE_FAULT_EN
      if (m_handler && !is_irq) begin
        m_fault = 1; m_ack = 1;
        return;
      end
`endif
      m_ack = 1; m_valid = 1; m_ret = 0; m_handler = 0;
      m_mepc = mepc_in;
      m_int  = is_irq;
      m_onehot = 0;
      if (code < 16) m_onehot[code[3:0]] = 1'b1;
      m_pc = mtvec_in & 32'hFFFF_FFFC;
      if (mtvec_in[1:0] == 2'd1 && is_irq) m_pc = m_pc + code * 4;
      m_mpie = m_mie; m_mie = 0; m_mpp = 2'b11;
    end else if (m_handler && !m_valid && mret_in) begin
      m_mie = m_mpie; m_mpie = 1; m_mpp = 2'b11;
      m_valid = 1; m_ret = 1; m_handler = 0;
      m_pc = m_mepc & 32'hFFFF_FFFC;
    end else begin
      if (csr_mstatus_we_i) begin
        m_mie  = csr_mstatus_wdata_i[3];
        m_mpie = csr_mstatus_wdata_i[7];
        m_mpp  = csr_mstatus_wdata_i[12:11];
      end
      if (m_valid && redirect_bus.redirect_ready_i) begin
        m_valid = 0;
        if (m_ret) begin
          m_intrap = 0; m_onehot = 0; m_int = 0;
        end else begin
          m_intrap = 1; m_handler = 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    check_output("ack", 32'(except_ack_o), 32'(m_ack));
    check_output("valid", 32'(redirect_bus.redirect_valid_o), 32'(m_valid));
    if (m_valid) check_output("pc", redirect_bus.redirect_pc_o, m_pc);
    check_output("mstatus", mstatus_out, model_mstatus());
    check_output("onehot", 32'(cause_onehot_o), 32'(m_onehot));
    check_output("is_int", 32'(is_interrupt_o), 32'(m_int));
    check_output("in_trap", 32'(in_trap_o), 32'(m_intrap));
`ifdef TRAP_DOUBLE_FAULT_EN
    check_output("double_fault", 32'(double_fault_o), 32'(m_fault));
`endif
  endtask

  // Inputs are set just after a falling edge; one call covers one rising edge.
  task automatic apply_stimulus();
    @(posedge clk_in);
    model_step();
    @(negedge clk_in);
    compare_all();
  endtask

  task automatic idle_inputs();
    rst_in = 0; except_flag = 0; mret_in = 0; csr_mstatus_we_i = 0;
    csr_mstatus_wdata_i = 0; redirect_bus.redirect_ready_i = 0;
  endtask

  task automatic csr_write(input logic [31:0] data);
    csr_mstatus_we_i = 1; csr_mstatus_wdata_i = data;
    apply_stimulus();
    csr_mstatus_we_i = 0;
  endtask

  initial begin
    idle_inputs();
    mcause_in = 0; mepc_in = 0; mtvec_in = 0;
    rst_in = 1;
    @(negedge clk_in);
    apply_stimulus();
    apply_stimulus();
    rst_in = 0;
    check_output("reset_mstatus", mstatus_out, 32'h0000_1800);
    check_output("reset_valid", 32'(redirect_bus.redirect_valid_o), 32'h0);

    // Direct exception with MIE set, then backpressure and MRET.
    csr_write(32'h0000_0008);
    except_flag = 1; mtvec_in = 32'h100; mcause_in = 2; mepc_in = 32'h40;
    apply_stimulus();
    except_flag = 0;
    check_output("t1_ack", 32'(except_ack_o), 32'h1);
    check_output("t1_pc", redirect_bus.redirect_pc_o, 32'h100);
    check_output("t1_onehot", 32'(cause_onehot_o), 32'h0004);
    check_output("t1_mstatus", mstatus_out, 32'h1880);
    repeat (3) apply_stimulus();
    check_output("t3_hold_valid", 32'(redirect_bus.redirect_valid_o), 32'h1);
    check_output("t3_hold_pc", redirect_bus.redirect_pc_o, 32'h100);
    redirect_bus.redirect_ready_i = 1;
    apply_stimulus();
    redirect_bus.redirect_ready_i = 0;
    mret_in = 1;
    apply_stimulus();
    mret_in = 0;
    check_output("t3_ret_pc", redirect_bus.redirect_pc_o, 32'h40);
    check_output("t3_mstatus", mstatus_out, 32'h1888);
    check_output("t3_in_trap_held", 32'(in_trap_o), 32'h1);
    redirect_bus.redirect_ready_i = 1;
    apply_stimulus();
    check_output("t3_in_trap_fall", 32'(in_trap_o), 32'h0);

    // Vectored interrupt, then the same interrupt while masked.
    redirect_bus.redirect_ready_i = 0;
    except_flag = 1; mtvec_in = 32'h201; mcause_in = 32'h8000_0007;
    apply_stimulus();
    except_flag = 0;
    check_output("t2_pc", redirect_bus.redirect_pc_o, 32'h21C);
    check_output("t2_is_int", 32'(is_interrupt_o), 32'h1);
    redirect_bus.redirect_ready_i = 1;
    apply_stimulus();
    mret_in = 1;
    apply_stimulus();
    mret_in = 0;
    apply_stimulus();
    csr_write(32'h0000_1800);
    except_flag = 1;
    repeat (3) apply_stimulus();
    check_output("t2_masked_ack", 32'(except_ack_o), 32'h0);
    check_output("t2_masked_valid", 32'(redirect_bus.redirect_valid_o), 32'h0);
    except_flag = 0;

    // Nested exception coincident with MRET inside the handler.
    csr_write(32'h0000_0008);
    except_flag = 1; mtvec_in = 32'h300; mcause_in = 1; mepc_in = 32'h80;
    apply_stimulus();
    except_flag = 0;
    apply_stimulus();
    except_flag = 1; mcause_in = 5; mepc_in = 32'h90; mret_in = 1;
    apply_stimulus();
    except_flag = 0; mret_in = 0;
`ifdef TRAP_DOUBLE_FAULT_EN
    check_output("t4_double_fault", 32'(double_fault_o), 32'h1);
    apply_stimulus();
    check_output("t4_fault_sticky", 32'(double_fault_o), 32'h1);
`else
    check_output("t4_reentry_ack", 32'(except_ack_o), 32'h1);
    check_output("t4_mstatus", mstatus_out, 32'h1800);
    check_output("t4_onehot", 32'(cause_onehot_o), 32'h0020);
    apply_stimulus();
    mret_in = 1;
    apply_stimulus();
    mret_in = 0;
    check_output("t4_ret_pc", redirect_bus.redirect_pc_o, 32'h90);
    apply_stimulus();
`endif

    // Reset while an entry redirect is stalled.
    rst_in = 1; apply_stimulus(); rst_in = 0;
    csr_write(32'h0000_0008);
    redirect_bus.redirect_ready_i = 0;
    except_flag = 1; mcause_in = 3;
    apply_stimulus();
    except_flag = 0;
    rst_in = 1;
    apply_stimulus();
    rst_in = 0;
    check_output("t5_valid", 32'(redirect_bus.redirect_valid_o), 32'h0);
    check_output("t5_mstatus", mstatus_out, 32'h1800);
    check_output("t5_ack", 32'(except_ack_o), 32'h0);

    // CSR write alone, then colliding with trap entry.
    csr_write(32'hFFFF_FFFF);
    check_output("t6_csr", mstatus_out, 32'h1888);
    csr_mstatus_we_i = 1; csr_mstatus_wdata_i = 32'hFFFF_FFFF;
    except_flag = 1; mcause_in = 4;
    apply_stimulus();
    csr_mstatus_we_i = 0; except_flag = 0;
    check_output("t6_collide", mstatus_out, 32'h1880);

    rst_in = 1; apply_stimulus(); rst_in = 0;

    // Randomized traffic; the encoder holds a trap until acknowledged or withdraws it.
    for (int i = 0; i < 4000; i++) begin
      rst_in = ($urandom_range(0, 249) == 0);
      if (except_flag && (m_ack || $urandom_range(0, 19) == 0)) begin
        except_flag = 0;
      end else if (!except_flag && $urandom_range(0, 3) == 0) begin
        except_flag = 1;
        mepc_in  = $urandom;
        mtvec_in = $urandom;
        case ($urandom_range(0, 3))
          0, 3:    mcause_in = $urandom_range(0, 19);
          1:       mcause_in = 32'h8000_0000 | $urandom_range(0, 19);
          default: mcause_in = $urandom;
        endcase
      end
      mret_in = ($urandom_range(0, 7) == 0);
      csr_mstatus_we_i = ($urandom_range(0, 9) == 0);
      csr_mstatus_wdata_i = $urandom;
      redirect_bus.redirect_ready_i = 1'($urandom_range(0, 1));
      apply_stimulus();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trap_decoder.md
Name: trap_decoder

Overview:
Consumes the trap record latched by the exception encoder (`except_flag`, `mcause`, `mepc`, `mtvec`) and drives the fetch redirect into the trap handler.
- Owns the machine `mstatus` register: MIE/MPIE/MPP stacking on trap entry and on MRET.
- Decodes the cause into a one-hot vector for downstream counters/debug.
- Sits between the encoder and the fetch stage. The redirect uses a valid/ready handshake.

Parameters:
- XLEN, 32, data/address width.
- NUM_CAUSE, 16, width of the one-hot cause vector.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  reset.
- except_flag  in  1  trap pending from encoder; held until acknowledged.
- mcause_in  in  XLEN  trap cause; bit 31 = interrupt.
- mepc_in  in  XLEN  faulting/return PC.
- mtvec_in  in  XLEN  trap vector base; [1:0] = mode.
- mret_in  in  1  MRET retired (single-cycle pulse).
- csr_mstatus_we_i  in  1  CSR instruction write to mstatus.
- csr_mstatus_wdata_i  in  XLEN  CSR write data.
- except_ack_o  out  1  one-cycle pulse: trap consumed.
- redirect_valid_o  out  1  redirect PC valid.
- redirect_pc_o  out  XLEN  redirect target.
- redirect_ready_i  in  1  fetch accepts redirect.
- mstatus_out  out  XLEN  current mstatus.
- cause_onehot_o  out  NUM_CAUSE  decoded cause of the trap being serviced.
- is_interrupt_o  out  1  serviced trap is an interrupt.
- in_trap_o  out  1  handler executing.

Behaviour:
Interface: one clock, `clk_in`. Reset `rst_in` is synchronous and active-high.

Reset values:
- All outputs 0, except `mstatus_out` = 32'h0000_1800 (MPP = M).
- FSM = IDLE; latched mepc = 0.

FSM states: IDLE, ENTRY, HANDLER, RETURN.

Trap acceptance:
- Interrupts (`mcause_in[31]`=1) are accepted only when `mstatus_out[3]` (MIE) = 1.
- Exceptions are always accepted.
- Acceptance is evaluated only in IDLE and HANDLER.

IDLE:
- Accepted trap sampled at edge N moves FSM to ENTRY at edge N.
- During cycle N+1: `except_ack_o`=1 (single cycle); `redirect_valid_o`=1.
- At edge N also latch: mepc; `is_interrupt_o`; `cause_onehot_o`.
  - `cause_onehot_o[k]`=1 iff `mcause_in[30:0]`==k and k<NUM_CAUSE; otherwise all zeros.
- Target PC, with base = {`mtvec_in[31:2]`, 2'b00}:
  - mode 0: base.
  - mode 1 and interrupt: base + (`mcause_in[30:0]` << 2), mod 2^XLEN.
  - mode 1 and exception: base.
  - modes 2/3 (reserved): treated as mode 0.
- mstatus update at edge N: MPIE[7] <= MIE[3]; MIE <= 0; MPP[12:11] <= 2'b11.

ENTRY:
- Hold `redirect_valid_o`/`redirect_pc_o` stable until `redirect_ready_i`=1.
- On handshake go to HANDLER; `redirect_valid_o` drops the next cycle.
- `except_flag` is not acknowledged in ENTRY or RETURN.

HANDLER:
- `in_trap_o`=1.
- On `mret_in`: MIE <= MPIE; MPIE <= 1; MPP <= 2'b11. Go to RETURN with `redirect_pc_o` = {mepc_latched[31:2], 2'b00}.
- Accepted trap (exception; interrupts are masked since MIE=0) re-enters exactly as in IDLE and overwrites the latched state.

RETURN:
- Hold the redirect until handshake, then go to IDLE.
- On leaving RETURN: `in_trap_o`=0; `cause_onehot_o` and `is_interrupt_o` cleared.

Simultaneous events:
- Trap + `mret_in` in HANDLER: trap wins; MRET ignored.
- Trap entry or MRET + `csr_mstatus_we_i`: hardware update wins; CSR write dropped.
- `mret_in` in IDLE/ENTRY/RETURN: ignored.
- CSR writes otherwise take effect at the next edge; writable bits are [3], [7], [12:11]; others read 0.

Reset mid-handshake: FSM goes to IDLE at that edge; `redirect_valid_o` is 0 the next cycle; no ack is issued.

Optional Feature:
Macro `TRAP_DOUBLE_FAULT_EN`.
- Defined: an exception accepted while in HANDLER goes to state FAULT instead of re-entering.
  - FAULT: `except_ack_o` pulses once; `redirect_valid_o`=0; output `double_fault_o` (1 bit, extra port) = 1.
  - FAULT is sticky until `rst_in`; mstatus is not modified.
- Undefined: nested exceptions re-enter as described above; no `double_fault_o` port.

Test Plan:
1. Direct exception: `mtvec_in`=32'h0000_0100, `mcause_in`=2, `mepc_in`=32'h0000_0040, MIE=1 → ack pulse 1 cycle; `redirect_pc_o`=32'h100; `cause_onehot_o`=16'h0004; `mstatus_out`=32'h1880.
2. Vectored interrupt: `mtvec_in`=32'h0000_0201, `mcause_in`=32'h8000_0007, MIE=1 → `redirect_pc_o`=32'h21C; `is_interrupt_o`=1. Same stimulus with MIE=0 → no ack; FSM stays IDLE.
3. Backpressure then MRET: `redirect_ready_i` low 3 cycles → valid and PC held stable; after handshake, `mret_in` → `redirect_pc_o`=32'h40; `mstatus_out` MIE=1, MPIE=1; `in_trap_o` falls after the return handshake.
4. Nested exception with `mret_in` in the same cycle in HANDLER, `mcause_in`=5 → re-entry (mstatus MIE=0, MPIE=0); MRET ignored. With `TRAP_DOUBLE_FAULT_EN`: `double_fault_o`=1 and sticky.
5. `rst_in` asserted during ENTRY with `redirect_ready_i`=0 → next cycle `redirect_valid_o`=0, `mstatus_out`=32'h1800, FSM IDLE.
6. `csr_mstatus_wdata_i`=32'hFFFF_FFFF written in IDLE → `mstatus_out`=32'h1888. The same write coincident with trap entry → `mstatus_out` shows the trap update only.
